// File: rtl/freq_gate_controller.sv
// Gated-window frequency measurement controller: opens a fixed gate, steers an
// external BCD counter with synchronized signal edges, and latches the final count.
module freq_gate_controller #(
  parameter int DIGITS_NUM  = 6,
  parameter int GATE_CYCLES = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    signal_in,
  input  logic [4*DIGITS_NUM-1:0] digits_in,
  input  logic                    carry_in,
  output logic                    counter_reset_out,
  output logic                    counter_enable_out,
  output logic                    gate_active_out,
  output logic [4*DIGITS_NUM-1:0] result_out,
  output logic                    overflow_out,
  output logic                    result_valid_out
);

  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_GATE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LATCH  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    history_q;
  logic                    rise_s;
  logic                    counter_reset_q;
  logic                    counter_enable_q;
  logic                    gate_active_q;
  logic                    sticky_ovf_q;
  logic [4*DIGITS_NUM-1:0] result_q;
  logic                    overflow_q;
  logic                    result_valid_q;

  // Metastability synchronizer for signal_in plus one history stage for edge detection.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync_q    <= '0;
      history_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], signal_in};
      history_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_s = sync_q[SYNC_STAGES-1] & ~history_q;

  // Next-state and gate timer; the timer returns to zero when the gate closes.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_CLEAR: begin
        state_d = ST_GATE;
        timer_d = '0;
      end
      ST_GATE: begin
        if (timer_q == TIMER_LAST) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_SETTLE: state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_CLEAR;
      default: begin
        state_d = ST_CLEAR;
        timer_d = '0;
      end
    endcase
  end

  // Measurement FSM with all outputs registered from the next/current state.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q          <= ST_CLEAR;
      timer_q          <= '0;
      counter_reset_q  <= 1'b1;
      counter_enable_q <= 1'b0;
      gate_active_q    <= 1'b0;
      sticky_ovf_q     <= 1'b0;
      result_q         <= '0;
      overflow_q       <= 1'b0;
      result_valid_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      counter_reset_q  <= (state_d == ST_CLEAR);
      gate_active_q    <= (state_d == ST_GATE);
      // Edges seen outside GATE fall into the dead time and are dropped.
      counter_enable_q <= rise_s & (state_q == ST_GATE);
      if (state_q == ST_CLEAR) begin
        sticky_ovf_q <= 1'b0;
      end else if (carry_in & counter_enable_q) begin
        sticky_ovf_q <= 1'b1;
      end else begin
        sticky_ovf_q <= sticky_ovf_q;
      end
      result_valid_q <= (state_q == ST_LATCH);
      if (state_q == ST_LATCH) begin
        result_q   <= digits_in;
        overflow_q <= sticky_ovf_q;
      end else begin
        result_q   <= result_q;
        overflow_q <= overflow_q;
      end
    end
  end

  assign counter_reset_out  = counter_reset_q;
  assign counter_enable_out = counter_enable_q;
  assign gate_active_out    = gate_active_q;
  assign result_out         = result_q;
  assign overflow_out       = overflow_q;
  assign result_valid_out   = result_valid_q;

endmodule

// File: tb/tb_freq_gate_controller.sv
// Bench for freq_gate_controller: two configurations, each driving a behavioural
// BCD counter, checked every cycle against a period/edge-count model.
module tb_freq_gate_controller;

  localparam int SYNC = 2;
  localparam int G_A  = 100;
  localparam int G_B  = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, sig_a, carry_a, cr_a, ce_a, ga_a, ov_a, rv_a;
  logic [23:0] digits_a, res_a;
  logic        rst_b, sig_b, carry_b, cr_b, ce_b, ga_b, ov_b, rv_b;
  logic [23:0] digits_b_full;
  logic [7:0]  digits_b, res_b;

  int ctr_a = 0;
  int ctr_b = 0;
  int checks = 0;
  int failures = 0;

  int          m_n[2];
  int          m_cnt[2];
  logic [23:0] m_res[2];
  logic        m_ovf[2];
  bit          m_x[2][0:8191];

  freq_gate_controller #(.DIGITS_NUM(6), .GATE_CYCLES(G_A), .SYNC_STAGES(SYNC)) dut_a (
    .clk_in(clk), .reset_in(rst_a), .signal_in(sig_a), .digits_in(digits_a),
    .carry_in(carry_a), .counter_reset_out(cr_a), .counter_enable_out(ce_a),
    .gate_active_out(ga_a), .result_out(res_a), .overflow_out(ov_a),
    .result_valid_out(rv_a));

  freq_gate_controller #(.DIGITS_NUM(2), .GATE_CYCLES(G_B), .SYNC_STAGES(SYNC)) dut_b (
    .clk_in(clk), .reset_in(rst_b), .signal_in(sig_b), .digits_in(digits_b),
    .carry_in(carry_b), .counter_reset_out(cr_b), .counter_enable_out(ce_b),
    .gate_active_out(ga_b), .result_out(res_b), .overflow_out(ov_b),
    .result_valid_out(rv_b));

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int d);
    int r;
    r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  // Attached BCD counters (environment, not the checker).
  assign digits_a      = to_bcd(ctr_a);
  assign carry_a       = (ctr_a == 999999);
  assign digits_b_full = to_bcd(ctr_b);
  assign digits_b      = digits_b_full[7:0];
  assign carry_b       = (ctr_b == 99);

  always @(posedge clk) begin
    if (cr_a) ctr_a <= 0;
    else if (ce_a) ctr_a <= (ctr_a + 1) % 1000000;
    if (cr_b) ctr_b <= 0;
    else if (ce_b) ctr_b <= (ctr_b + 1) % 100;
  end

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_gate(input int k, input int g);
    int ph;
    ph = k % (g + 3);
    return (ph >= 1) && (ph <= g);
  endfunction

  function automatic bit rise_at(input int u, input int k);
    int j;
    j = k - SYNC;
    if (j < 0) return 1'b0;
    if (j == 0) return m_x[u][0];
    return m_x[u][j] && !m_x[u][j-1];
  endfunction

  // Model: cycle n after release has phase n mod (G+3); phase 0 = clear, 1..G = gate.
  // A signal edge surfaces SYNC cycles later; if that cycle is in the gate, it is
  // counted one cycle later. The result of a period appears at the next phase 0.
  task automatic model_unit(input int u, input int dig, input int g, input logic rst,
                            input logic sig, input logic cr, input logic ce, input logic ga,
                            input logic [23:0] res, input logic ov, input logic rv);
    string p;
    int n, ph;
    bit en;
    p = (u == 0) ? "a" : "b";
    if (rst) begin
      m_n[u] = 0;
      m_cnt[u] = 0;
      m_res[u] = '0;
      m_ovf[u] = 1'b0;
      check({p, "_rst_counter_reset"}, {23'd0, cr}, 24'd1);
      check({p, "_rst_enable"}, {23'd0, ce}, 24'd0);
      check({p, "_rst_gate"}, {23'd0, ga}, 24'd0);
      check({p, "_rst_result"}, res, 24'd0);
      check({p, "_rst_overflow"}, {23'd0, ov}, 24'd0);
      check({p, "_rst_valid"}, {23'd0, rv}, 24'd0);
    end else begin
      n = m_n[u];
      m_x[u][n] = sig;
      ph = n % (g + 3);
      if (ph == 0 && n > 0) begin
        m_res[u] = to_bcd(m_cnt[u] % pow10(dig));
        m_ovf[u] = (m_cnt[u] >= pow10(dig));
        m_cnt[u] = 0;
      end
      en = (n >= 1) && in_gate(n - 1, g) && rise_at(u, n - 1);
      if (en) m_cnt[u]++;
      check({p, "_counter_reset"}, {23'd0, cr}, {23'd0, (ph == 0)});
      check({p, "_gate_active"}, {23'd0, ga}, {23'd0, in_gate(n, g)});
      check({p, "_counter_enable"}, {23'd0, ce}, {23'd0, en});
      check({p, "_result_valid"}, {23'd0, rv}, {23'd0, (ph == 0 && n > 0)});
      check({p, "_result"}, res, m_res[u]);
      check({p, "_overflow"}, {23'd0, ov}, {23'd0, m_ovf[u]});
      if (n < 8191) m_n[u] = n + 1;
    end
  endtask

  always @(negedge clk) begin
    model_unit(0, 6, G_A, rst_a, sig_a, cr_a, ce_a, ga_a, res_a, ov_a, rv_a);
    model_unit(1, 2, G_B, rst_b, sig_b, cr_b, ce_b, ga_b, {16'd0, res_b}, ov_b, rv_b);
  end

  function automatic logic sig_val(input int mode, input int c);
    case (mode)
      1: return (c >= 10) && ((c % 10) < 5);
      2: return (c >= 98);
      4: return (c < 403) && ((c % 2) == 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_a(input int mode, input int ncyc);
    rst_a = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      sig_a = sig_val(mode, c);
      @(negedge clk);
      if (c > 0 && (c % 103) == 0) begin
        check("a_lit_valid_pulse", {23'd0, rv_a}, 24'd1);
        check("a_lit_overflow", {23'd0, ov_a}, 24'd0);
        if (mode == 1) begin
          checks++;
          if (!(res_a == 24'h000009 || res_a == 24'h000010 || res_a == 24'h000011)) begin
            failures++;
            $display("FAIL a_lit_square_result: got %0h expected 000010 +/-1", res_a);
          end
        end else if (mode == 2 && c == 103) begin
          check("a_lit_last_edge_result", res_a, 24'h000001);
        end else begin
          check("a_lit_zero_result", res_a, 24'h000000);
        end
      end
      if (mode == 2 && c == 101) check("a_lit_enable_in_settle", {23'd0, ce_a}, 24'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_b(input int ncyc);
    rst_b = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      sig_b = sig_val(4, c);
      @(negedge clk);
      if (c == 403) begin
        check("b_lit_overflow_set", {23'd0, ov_b}, 24'd1);
        check("b_lit_counter_reset_after_latch", {23'd0, cr_b}, 24'd1);
        check("b_lit_valid_1", {23'd0, rv_b}, 24'd1);
      end
      if (c == 806) begin
        check("b_lit_overflow_clear", {23'd0, ov_b}, 24'd0);
        check("b_lit_result_zero", {16'd0, res_b}, 24'h000000);
        check("b_lit_valid_2", {23'd0, rv_b}, 24'd1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("a_lit_reset_counter_reset", {23'd0, cr_a}, 24'd1);
    check("a_lit_reset_gate", {23'd0, ga_a}, 24'd0);
    @(posedge clk);
    #1;
    run_a(0, 310);
    rst_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_a(1, 310);
    rst_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_a(2, 210);
    rst_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_a(1, 50);
    rst_a = 1'b1;
    #1;
    check("a_lit_midreset_gate", {23'd0, ga_a}, 24'd0);
    check("a_lit_midreset_counter_reset", {23'd0, cr_a}, 24'd1);
    check("a_lit_midreset_valid", {23'd0, rv_a}, 24'd0);
    repeat (2) @(posedge clk);
    #1;
    run_a(1, 210);
    rst_a = 1'b1;
    run_b(810);
    rst_b = 1'b1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
